// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that shares one uart_tx between N_REQ byte-stream requesters.
// A grant is held until a byte tagged last has gone out, or until MAX_BURST bytes have been sent.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_busy_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OFF_W = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [OFF_W-1:0] N_EXT     = OFF_W'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;

    logic [N_REQ-1:0]   rot_valid;
    logic               win_found;
    logic [OFF_W-1:0]   win_off;
    logic [OFF_W-1:0]   win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_onehot;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic [CNT_W-1:0]   cnt_inc;
    logic [PTR_W-1:0]   next_ptr;

    // Rotate the valid vector so bit 0 is the rr_ptr owner, pick the first set bit,
    // then map the offset back to an absolute requester index.
    always_comb begin
        rot_valid = N_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!win_found && rot_valid[j]) begin
                win_found = 1'b1;
                win_off   = OFF_W'(j);
            end
        end
        win_sum    = {1'b0, rr_ptr_q} + win_off;
        win_idx    = (win_sum >= N_EXT) ? PTR_W'(win_sum - N_EXT) : PTR_W'(win_sum);
        win_onehot = N_REQ'(1) << win_idx;
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                sel_data = sel_data | req_data_i[8*k +: 8];
            end
        end
        sel_valid = |(grant_q & req_valid_i);
        sel_last  = |(grant_q & req_last_i);
    end

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        last_d      = last_q;
        req_ready_o = '0;
        tx_start_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // uart_tx may still be finishing a byte from before a reset
                if (!tx_busy_i && win_found) begin
                    grant_d = win_onehot;
                    gidx_d  = win_idx;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                req_ready_o = grant_q & req_valid_i;
                if (sel_valid) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    state_d = START;
                end else if (cnt_q == '0) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            START: begin
                tx_start_o = 1'b1;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy_i) begin
                    cnt_d = cnt_inc;
                    if (last_q || (cnt_inc == BURST_END)) begin
                        rr_ptr_d = next_ptr;
                        grant_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_data_o = data_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);

endmodule
